// File: rtl/ip_receive.sv
// MII (4-bit) receiver that filters Ethernet/IPv4/UDP frames addressed to the board and
// streams the UDP payload as 32-bit words. Optional macro UDP_PORT_FILTER_EN adds a UDP destination-port filter.
module ip_receive #(
    parameter logic [47:0] BOARD_MAC  = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] BOARD_IP   = 32'hFF_FF_FF_FF,
    parameter logic [15:0] BOARD_PORT = 16'd32768
) (
    input  logic        eth_rx_clk,
    input  logic        rst_n,
    input  logic        eth_rxdv,
    input  logic [3:0]  eth_rx_data,
    output logic        rec_en,
    output logic [31:0] rec_data,
    output logic        rec_end,
    output logic [15:0] rec_data_num
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, REC_DATA, REC_END
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [3:0]  ihl, ihl_nxt;
    logic [15:0] pay_num, pay_nxt;
    logic [39:0] sr, sr_nxt;
    logic [23:0] acc, acc_nxt;
    logic        en_nxt, end_nxt;
    logic [31:0] data_nxt;
    logic [15:0] num_nxt;
    logic        half, armed;
    logic [3:0]  nib_lo;

    logic        byte_vld;
    logic [7:0]  rx_byte;
    logic [31:0] word;
    logic [15:0] udp_len, ip_last;

    assign byte_vld = eth_rxdv && half;
    assign rx_byte  = {eth_rx_data, nib_lo};
    assign word     = {acc, rx_byte};
    assign udp_len  = {sr[7:0], rx_byte};
    assign ip_last  = {10'd0, ihl, 2'b00} - 16'd1;

`ifndef UDP_PORT_FILTER_EN
    logic unused_port;
    assign unused_port = ^BOARD_PORT;
`endif

    // armed stays low after reset until the line goes idle, so a frame cut by reset is never picked up mid-way
    always_ff @(posedge eth_rx_clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            ihl          <= '0;
            pay_num      <= '0;
            sr           <= '0;
            acc          <= '0;
            half         <= 1'b0;
            nib_lo       <= '0;
            armed        <= 1'b0;
            rec_en       <= 1'b0;
            rec_end      <= 1'b0;
            rec_data     <= '0;
            rec_data_num <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            ihl          <= ihl_nxt;
            pay_num      <= pay_nxt;
            sr           <= sr_nxt;
            acc          <= acc_nxt;
            half         <= eth_rxdv ? ~half : 1'b0;
            if (eth_rxdv && !half)
                nib_lo <= eth_rx_data;
            armed        <= armed | ~eth_rxdv;
            rec_en       <= en_nxt;
            rec_end      <= end_nxt;
            rec_data     <= data_nxt;
            rec_data_num <= num_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ihl_nxt   = ihl;
        pay_nxt   = pay_num;
        sr_nxt    = sr;
        acc_nxt   = acc;
        en_nxt    = 1'b0;
        end_nxt   = 1'b0;
        data_nxt  = rec_data;
        num_nxt   = rec_data_num;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (eth_rxdv && armed)
                    state_nxt = PREAMBLE;
            end
            PREAMBLE: begin
                if (!eth_rxdv)
                    state_nxt = IDLE;
                else if (byte_vld) begin
                    if (cnt < 16'd7) begin
                        if (rx_byte == 8'h55) cnt_nxt = cnt + 16'd1;
                        else                  state_nxt = REC_END;
                    end else if (rx_byte == 8'hD5) begin
                        state_nxt = ETH_HEAD;
                        cnt_nxt   = '0;
                    end else
                        state_nxt = REC_END;
                end
            end
            ETH_HEAD: begin
                if (!eth_rxdv)
                    state_nxt = IDLE;
                else if (byte_vld) begin
                    sr_nxt  = {sr[31:0], rx_byte};
                    cnt_nxt = cnt + 16'd1;
                    if (cnt == 16'd5 && {sr, rx_byte} != BOARD_MAC && {sr, rx_byte} != 48'hFF_FF_FF_FF_FF_FF)
                        state_nxt = REC_END;
                    else if (cnt == 16'd13) begin
                        if ({sr[7:0], rx_byte} == 16'h0800) begin
                            state_nxt = IP_HEAD;
                            cnt_nxt   = '0;
                        end else
                            state_nxt = REC_END;
                    end
                end
            end
            IP_HEAD: begin
                if (!eth_rxdv)
                    state_nxt = IDLE;
                else if (byte_vld) begin
                    sr_nxt  = {sr[31:0], rx_byte};
                    cnt_nxt = cnt + 16'd1;
                    if (cnt == 16'd0) begin
                        ihl_nxt = rx_byte[3:0];
                        if (rx_byte[3:0] < 4'd5) state_nxt = REC_END;
                    end else if (cnt == 16'd9 && rx_byte != 8'd17)
                        state_nxt = REC_END;
                    else if (cnt == 16'd19 && {sr[23:0], rx_byte} != BOARD_IP)
                        state_nxt = REC_END;
                    else if (cnt >= 16'd19 && cnt == ip_last) begin
                        // any option bytes between 20 and IHL*4 are simply counted past
                        state_nxt = UDP_HEAD;
                        cnt_nxt   = '0;
                    end
                end
            end
            UDP_HEAD: begin
                if (!eth_rxdv)
                    state_nxt = IDLE;
                else if (byte_vld) begin
                    sr_nxt  = {sr[31:0], rx_byte};
                    cnt_nxt = cnt + 16'd1;
`ifdef UDP_PORT_FILTER_EN
                    if (cnt == 16'd3 && {sr[7:0], rx_byte} != BOARD_PORT)
                        state_nxt = REC_END;
                    else
`endif
                    if (cnt == 16'd5) begin
                        if (udp_len < 16'd8) state_nxt = REC_END;
                        else                 pay_nxt   = udp_len - 16'd8;
                    end else if (cnt == 16'd7) begin
                        if (pay_num == 16'd0) begin
                            end_nxt   = 1'b1;
                            num_nxt   = '0;
                            state_nxt = REC_END;
                        end else begin
                            state_nxt = REC_DATA;
                            cnt_nxt   = '0;
                            acc_nxt   = '0;
                        end
                    end
                end
            end
            REC_DATA: begin
                if (!eth_rxdv)
                    state_nxt = IDLE;
                else if (byte_vld) begin
                    cnt_nxt = cnt + 16'd1;
                    acc_nxt = word[23:0];
                    if (cnt[1:0] == 2'd3 || cnt == pay_num - 16'd1) begin
                        // left-justify a partial last word so unused low bytes read as zero
                        en_nxt   = 1'b1;
                        data_nxt = word << {~cnt[1:0], 3'b000};
                        acc_nxt  = '0;
                        if (cnt == pay_num - 16'd1) begin
                            end_nxt   = 1'b1;
                            num_nxt   = pay_num;
                            state_nxt = REC_END;
                        end
                    end
                end
            end
            REC_END: begin
                if (!eth_rxdv)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ip_receive.sv
// Self-checking bench for ip_receive: frames built from header fields, acceptance and output
// timing predicted from the frame contents, DUT checked every cycle against that prediction.
module tb_ip_receive;

    localparam logic [47:0] MAC  = 48'h00_11_22_33_44_55;
    localparam logic [31:0] IP   = 32'hC0_A8_01_02;
    localparam logic [15:0] PORT = 16'd32768;

    logic        eth_rx_clk = 1'b0;
    logic        rst_n;
    logic        eth_rxdv;
    logic [3:0]  eth_rx_data;
    logic        rec_en;
    logic [31:0] rec_data;
    logic        rec_end;
    logic [15:0] rec_data_num;

    ip_receive #(.BOARD_MAC(MAC), .BOARD_IP(IP), .BOARD_PORT(PORT)) dut (
        .eth_rx_clk(eth_rx_clk), .rst_n(rst_n), .eth_rxdv(eth_rxdv), .eth_rx_data(eth_rx_data),
        .rec_en(rec_en), .rec_data(rec_data), .rec_end(rec_end), .rec_data_num(rec_data_num)
    );

    always #5 eth_rx_clk = ~eth_rx_clk;

    typedef struct { int c; logic [31:0] v; } ev_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rst_q = 1'b0;
    ev_t wq[$];
    ev_t eq[$];
    logic [31:0] mlog[$];
    logic [31:0] dlog[$];
    logic [15:0] dend[$];
    logic [31:0] last_w = '0;
    logic [7:0] fr[$];
    logic [7:0] pay[$];
    int po, n;
    bit ok;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic ev_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    always @(posedge eth_rx_clk) begin
        cyc   = cyc + 1;
        rst_q = rst_n;
    end

    always @(negedge eth_rx_clk) begin
        if (!rst_q) begin
            chk("reset_rec_en", 32'(rec_en), 0);
            chk("reset_rec_end", 32'(rec_end), 0);
            chk("reset_rec_data", rec_data, 0);
            chk("reset_rec_data_num", 32'(rec_data_num), 0);
            last_w = '0;
        end else begin
            if (rec_en) begin
                if (wq.size() != 0 && wq[0].c == cyc) begin
                    chk("rec_data", rec_data, wq[0].v);
                    last_w = wq[0].v;
                    void'(wq.pop_front());
                end else begin
                    ev_fail("rec_en_spurious");
                    last_w = rec_data;
                end
                dlog.push_back(rec_data);
            end else begin
                if (wq.size() != 0 && wq[0].c <= cyc) begin
                    ev_fail("rec_en_missing");
                    void'(wq.pop_front());
                end
                chk("rec_data_hold", rec_data, last_w);
            end
            if (rec_end) begin
                if (eq.size() != 0 && eq[0].c == cyc) begin
                    chk("rec_data_num", 32'(rec_data_num), eq[0].v);
                    void'(eq.pop_front());
                end else
                    ev_fail("rec_end_spurious");
                dend.push_back(rec_data_num);
            end else if (eq.size() != 0 && eq[0].c <= cyc) begin
                ev_fail("rec_end_missing");
                void'(eq.pop_front());
            end
        end
    end

    task automatic nib(input logic dv, input logic [3:0] d);
        @(posedge eth_rx_clk);
        #1;
        eth_rxdv    = dv;
        eth_rx_data = d;
    endtask

    // payload word that must be strobed when payload byte i completes
    function automatic logic [31:0] mword(input int i);
        logic [31:0] w = '0;
        int base = i - (i % 4);
        for (int k = 0; k < 4; k++)
            w = {w[23:0], (base + k <= i) ? pay[base + k] : 8'h00};
        return w;
    endfunction

    task automatic build(input logic [47:0] dmac, input logic [15:0] et, input logic [3:0] ihl,
                         input logic [7:0] proto, input logic [31:0] dip, input logic [15:0] dport,
                         input logic [15:0] ulen, input int npay, input int pad,
                         input logic [7:0] pay0, input bit rnd, input bit bad_pre);
        int iplen;
        bit port_ok;
        fr.delete();
        pay.delete();
        for (int i = 0; i < 7; i++) fr.push_back((bad_pre && i == 3) ? 8'h54 : 8'h55);
        fr.push_back(8'hD5);
        for (int i = 0; i < 6; i++) fr.push_back(dmac[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) fr.push_back(8'($urandom));
        fr.push_back(et[15:8]);
        fr.push_back(et[7:0]);
        iplen = (ihl < 4'd5) ? 20 : 4 * int'(ihl);
        for (int k = 0; k < iplen; k++) begin
            if (k == 0)                 fr.push_back({4'h4, ihl});
            else if (k == 9)            fr.push_back(proto);
            else if (k >= 16 && k < 20) fr.push_back(dip[31 - 8*(k-16) -: 8]);
            else                        fr.push_back(8'($urandom));
        end
        fr.push_back(8'($urandom));
        fr.push_back(8'($urandom));
        fr.push_back(dport[15:8]);
        fr.push_back(dport[7:0]);
        fr.push_back(ulen[15:8]);
        fr.push_back(ulen[7:0]);
        fr.push_back(8'($urandom));
        fr.push_back(8'($urandom));
        for (int i = 0; i < npay; i++) begin
            pay.push_back(rnd ? 8'($urandom) : pay0 + 8'(i));
            fr.push_back(pay[i]);
        end
        for (int i = 0; i < pad; i++) fr.push_back(8'($urandom));
`ifdef UDP_PORT_FILTER_EN
        port_ok = (dport == PORT);
`else
        port_ok = 1'b1;
`endif
        ok = !bad_pre && (dmac == MAC || dmac == 48'hFF_FF_FF_FF_FF_FF) && et == 16'h0800 &&
             ihl >= 4'd5 && proto == 8'd17 && dip == IP && ulen >= 16'd8 && port_ok;
        n  = int'(ulen) - 8;
        po = 8 + 14 + iplen + 8;
    endtask

    // cut: number of bytes sent before eth_rxdv drops (<0 = whole frame); rst_at: byte hit by reset
    task automatic send(input int cut, input int rst_at);
        bit dead = 1'b0;
        ev_t e;
        for (int j = 0; j < fr.size(); j++) begin
            if (j == cut) break;
            if (j == rst_at) begin
                nib(1'b1, fr[j][3:0]);
                rst_n = 1'b0;
                dead  = 1'b1;
                nib(1'b1, fr[j][7:4]);
                rst_n = 1'b1;
                continue;
            end
            nib(1'b1, fr[j][3:0]);
            nib(1'b1, fr[j][7:4]);
            if (ok && !dead) begin
                if (n == 0 && j == po - 1) begin
                    e.c = cyc + 1; e.v = 0; eq.push_back(e);
                end
                if (j >= po && j - po < n) begin
                    if ((j - po) % 4 == 3 || j - po == n - 1) begin
                        e.c = cyc + 1; e.v = mword(j - po);
                        wq.push_back(e);
                        mlog.push_back(e.v);
                    end
                    if (j - po == n - 1) begin
                        e.c = cyc + 1; e.v = 32'(n); eq.push_back(e);
                    end
                end
            end
        end
        repeat (3 + $urandom_range(0, 3)) nib(1'b0, 4'h0);
        chk("drain_words", 32'(wq.size()), 0);
        chk("drain_ends", 32'(eq.size()), 0);
    endtask

    task automatic clr_logs();
        mlog.delete();
        dlog.delete();
        dend.delete();
    endtask

    task automatic good_frame(input int npay);
        build(MAC, 16'h0800, 4'd5, 8'd17, IP, PORT, 16'(8 + npay), npay, 2, 8'h00, 1'b1, 1'b0);
        send(-1, -1);
    endtask

    initial begin
        rst_n = 1'b0;
        eth_rxdv = 1'b0;
        eth_rx_data = 4'h0;
        repeat (4) nib(1'b0, 4'h0);
        rst_n = 1'b1;
        repeat (2) nib(1'b0, 4'h0);

        clr_logs();
        build(MAC, 16'h0800, 4'd5, 8'd17, IP, PORT, 16'd16, 8, 4, 8'h01, 1'b0, 1'b0);
        send(-1, -1);
        chk("s030_model_words", 32'(mlog.size()), 2);
        if (mlog.size() == 2) begin
            chk("s030_model_w0", mlog[0], 32'h01020304);
            chk("s030_model_w1", mlog[1], 32'h05060708);
        end
        chk("s030_words", 32'(dlog.size()), 2);
        if (dlog.size() == 2) begin
            chk("s030_w0", dlog[0], 32'h01020304);
            chk("s030_w1", dlog[1], 32'h05060708);
        end
        chk("s030_ends", 32'(dend.size()), 1);
        if (dend.size() == 1) chk("s030_num", 32'(dend[0]), 8);

        clr_logs();
        build(MAC, 16'h0800, 4'd5, 8'd17, IP, PORT, 16'd13, 5, 0, 8'hA1, 1'b0, 1'b0);
        send(-1, -1);
        chk("s031_model_w1", (mlog.size() == 2) ? mlog[1] : 32'hDEAD, 32'hA5000000);
        chk("s031_words", 32'(dlog.size()), 2);
        if (dlog.size() == 2) begin
            chk("s031_w0", dlog[0], 32'hA1A2A3A4);
            chk("s031_w1", dlog[1], 32'hA5000000);
        end
        chk("s031_num", (dend.size() == 1) ? 32'(dend[0]) : 32'hDEAD, 5);

        clr_logs();
        build(MAC, 16'h0800, 4'd5, 8'd17, IP ^ 32'h0000_0100, PORT, 16'd12, 4, 0, 8'h10, 1'b0, 1'b0);
        send(-1, -1);
        build(MAC, 16'h0800, 4'd5, 8'd6, IP, PORT, 16'd12, 4, 0, 8'h10, 1'b0, 1'b0);
        send(-1, -1);
        chk("s032_no_words", 32'(dlog.size()), 0);
        chk("s032_no_end", 32'(dend.size()), 0);
        good_frame(7);

        clr_logs();
        build(MAC, 16'h0800, 4'd5, 8'd17, IP, PORT, 16'd18, 10, 0, 8'h30, 1'b0, 1'b0);
        send(po + 3, -1);
        chk("s033_no_words", 32'(dlog.size()), 0);
        chk("s033_no_end", 32'(dend.size()), 0);
        good_frame(10);

        clr_logs();
        build(48'hFF_FF_FF_FF_FF_FF, 16'h0800, 4'd5, 8'd17, IP, PORT, 16'd8, 0, 6, 8'h00, 1'b0, 1'b0);
        send(-1, -1);
        chk("s034_no_words", 32'(dlog.size()), 0);
        chk("s034_num", (dend.size() == 1) ? 32'(dend[0]) : 32'hDEAD, 0);

        clr_logs();
        build(MAC, 16'h0800, 4'd5, 8'd17, IP, 16'd1234, 16'd12, 4, 0, 8'h40, 1'b0, 1'b0);
        send(-1, -1);
`ifdef UDP_PORT_FILTER_EN
        chk("s035_ends", 32'(dend.size()), 0);
`else
        chk("s035_ends", 32'(dend.size()), 1);
`endif

        clr_logs();
        build(MAC, 16'h0800, 4'd5, 8'd17, IP, PORT, 16'd20, 12, 0, 8'h50, 1'b0, 1'b0);
        send(-1, po + 5);
        chk("midreset_words", 32'(dlog.size()), 1);
        chk("midreset_no_end", 32'(dend.size()), 0);
        good_frame(3);

        build(MAC, 16'h0800, 4'd7, 8'd17, IP, PORT, 16'd14, 6, 1, 8'h60, 1'b0, 1'b0);
        send(-1, -1);
        build(MAC, 16'h0800, 4'd4, 8'd17, IP, PORT, 16'd14, 6, 1, 8'h60, 1'b0, 1'b0);
        send(-1, -1);

        for (int f = 0; f < 40; f++) begin
            logic [47:0] dm;
            int np, cut, ra;
            logic [15:0] ul;
            np = $urandom_range(0, 20);
            case ($urandom % 8)
                0:       dm = {$urandom, 16'($urandom)};
                1:       dm = 48'hFF_FF_FF_FF_FF_FF;
                default: dm = MAC;
            endcase
            ul = ($urandom % 12 == 0) ? 16'($urandom % 8) : 16'(8 + np);
            build(dm, ($urandom % 10 == 0) ? 16'h86DD : 16'h0800, 4'(5 + $urandom_range(0, 2)),
                  ($urandom % 10 == 0) ? 8'd6 : 8'd17,
                  ($urandom % 10 == 0) ? IP ^ (32'd1 << $urandom_range(0, 31)) : IP,
                  ($urandom % 5 == 0) ? 16'($urandom) : PORT, ul, np, $urandom_range(0, 5),
                  8'h00, 1'b1, ($urandom % 15 == 0));
            cut = ($urandom % 6 == 0) ? $urandom_range(1, fr.size() - 1) : -1;
            ra  = ($urandom % 12 == 0) ? $urandom_range(1, fr.size() - 1) : -1;
            send(cut, ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
